multicycle_alucontrol: RTL
==========================

MULTICYCLE_ALUCONTROL -- requirements
Module: multicycle_alucontrol

Interface
REQ-001 Parameter DATA_W, default 32, datapath width and multiply iteration count; power of two, >= 4.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_W), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present on aluop/func/shamt.
REQ-006 in_ready  output  1  block can accept a request; request accepted when in_valid && in_ready on a rising edge.
REQ-007 aluop  input  3  main-control opcode class.
REQ-008 func  input  3  R-type function field; used only when aluop==000.
REQ-009 shamt  input  SHAMT_W  shift amount for SLL requests.
REQ-010 mul_bit  input  1  current multiplier LSB from the datapath, used during MUL steps.
REQ-011 aluctr  output  3  ALU micro-operation for the current cycle.
REQ-012 uop_valid  output  1  aluctr is a live micro-op this cycle.
REQ-013 shift_en  output  1  datapath shifts the multiplier/product registers this cycle.
REQ-014 busy  output  1  a multi-cycle operation is in progress.
REQ-015 done  output  1  last micro-op of the accepted request is issued this cycle.

Function
REQ-016 aluctr codes SHALL be: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT, 110 SLL1 (shift left by one), 111 PASS.
REQ-017 aluop decode SHALL be: 000 R-type, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT, 110 MUL, 111 SLL.
REQ-018 R-type func decode SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR, 110 MUL, 111 SLL.
REQ-019 FSM states SHALL be IDLE, MUL, SHF; in_ready = (state==IDLE), combinational; busy = (state!=IDLE).
REQ-020 Single-cycle op accepted in IDLE: next cycle aluctr=decoded code, uop_valid=1, done=1, state stays IDLE; back-to-back single ops at one per cycle.
REQ-021 Cycle with no acceptance in IDLE: uop_valid=0, done=0, shift_en=0, aluctr=PASS.
REQ-022 MUL accepted: state->MUL, step counter loaded with DATA_W-1; exactly DATA_W MUL cycles follow.
REQ-023 Each MUL cycle: uop_valid=1, shift_en=1, aluctr = mul_bit ? ADD : PASS (combinational from mul_bit); counter decrements.
REQ-024 MUL cycle with counter==0: done=1; next state IDLE.
REQ-025 SLL accepted with shamt==N>0: state->SHF, counter loaded with N-1; exactly N cycles of aluctr=SLL1, uop_valid=1, shift_en=0; done on counter==0, then IDLE.
REQ-026 SLL with shamt==0: treated as single-cycle op, aluctr=PASS, uop_valid=1, done=1, state stays IDLE.
REQ-027 While busy, in_valid is ignored (in_ready=0); requests are not queued; aluop/func/shamt changes do not affect the operation in progress.
REQ-028 One-cycle bubble after every multi-cycle op: in_ready rises the cycle after done.
REQ-029 Counter width SHALL be SHAMT_W; no wrap-around is reachable.

Reset
REQ-030 On reset assertion, immediately and regardless of clock: state=IDLE, counter=0, aluctr=PASS, uop_valid=0, shift_en=0, done=0; busy=0, in_ready=1.
REQ-031 Reset mid-MUL or mid-SHF SHALL abort the operation with no done pulse; the first acceptable request is on the first rising edge after deassertion.

Structure
REQ-032 Package alu_pkg SHALL hold aluop codes, func codes, aluctr codes and the state enumeration.
REQ-033 Combinational decode (aluop/func -> aluctr plus is_mul/is_sll flags) SHALL be sub-module alucontrol_dec; FSM and counter stay in the top.

Verification
REQ-034 aluop=000, func 000..101 on consecutive accepted cycles -> aluctr 010,011,000,001,101,100 one cycle later each, done=1 every cycle, in_ready held 1.
REQ-035 aluop=001..101 back-to-back -> aluctr 010,011,000,001,101; func=111 ignored.
REQ-036 DATA_W=8, aluop=110, mul_bit pattern 1,0,1,1,0,0,0,0 -> 8 cycles shift_en=1, aluctr ADD,PASS,ADD,ADD,PASS×4, done only on 8th, in_ready=1 on 9th.
REQ-037 aluop=111, shamt=3 -> 3 cycles aluctr=110, done on 3rd; shamt=0 -> single PASS with done.
REQ-038 in_valid held high with new ops during MUL -> none accepted until in_ready=1; reset asserted at MUL step 4 -> outputs to reset values asynchronously, no done, next request accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared encodings for the multi-cycle ALU control block.
//   aluop_e : main-control opcode class
//   func_e  : R-type function field, also used as the unified operation class
//   aluctr_e: ALU micro-operation codes driven to the datapath
//   state_e : sequencer states
package alu_pkg;

  typedef enum logic [2:0] {
    CTR_AND  = 3'b000,
    CTR_OR   = 3'b001,
    CTR_ADD  = 3'b010,
    CTR_SUB  = 3'b011,
    CTR_XOR  = 3'b100,
    CTR_SLT  = 3'b101,
    CTR_SLL1 = 3'b110,
    CTR_PASS = 3'b111
  } aluctr_e;

  typedef enum logic [2:0] {
    OP_RTYPE = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_SLT   = 3'b101,
    OP_MUL   = 3'b110,
    OP_SLL   = 3'b111
  } aluop_e;

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_SUB = 3'b001,
    FN_AND = 3'b010,
    FN_OR  = 3'b011,
    FN_SLT = 3'b100,
    FN_XOR = 3'b101,
    FN_MUL = 3'b110,
    FN_SLL = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_SHF  = 2'b10
  } state_e;

endpackage

// File: rtl/alucontrol_dec.sv
// alucontrol_dec -- purely combinational opcode decode.
//   aluop  : main-control opcode class (R-type defers to func)
//   func   : R-type function field
//   ctr    : single-cycle ALU micro-op (PASS for MUL and SLL)
//   is_mul : request is a multiply
//   is_sll : request is a shift-left-logical
module alucontrol_dec
  import alu_pkg::*;
(
  input  logic [2:0] aluop,
  input  logic [2:0] func,
  output aluctr_e    ctr,
  output logic       is_mul,
  output logic       is_sll
);

  func_e op;

  // Fold the aluop classes onto the func encoding so the micro-op mapping
  // below is written only once.
  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    op = FN_ADD;
    case (aluop_e'(aluop))
      OP_RTYPE: op = func_e'(func);
      OP_ADD:   op = FN_ADD;
      OP_SUB:   op = FN_SUB;
      OP_AND:   op = FN_AND;
      OP_OR:    op = FN_OR;
      OP_SLT:   op = FN_SLT;
      OP_MUL:   op = FN_MUL;
      OP_SLL:   op = FN_SLL;
      default:  op = FN_ADD;
    endcase
  end

  always_comb begin
    ctr    = CTR_PASS;
    is_mul = 1'b0;
    is_sll = 1'b0;
    case (op)
      FN_ADD:  ctr = CTR_ADD;
      FN_SUB:  ctr = CTR_SUB;
      FN_AND:  ctr = CTR_AND;
      FN_OR:   ctr = CTR_OR;
      FN_SLT:  ctr = CTR_SLT;
      FN_XOR:  ctr = CTR_XOR;
      FN_MUL:  is_mul = 1'b1;
      FN_SLL:  is_sll = 1'b1;
      default: ctr = CTR_PASS;
    endcase
  end

endmodule

// File: rtl/multicycle_alucontrol.sv
// multicycle_alucontrol -- ALU control sequencer for a multi-cycle datapath.
// Single-cycle ops issue one micro-op the cycle after acceptance; MUL runs
// DATA_W shift/add steps driven by mul_bit; SLL runs shamt SLL1 steps.
//   clk, reset   : clock, asynchronous active-high reset
//   in_valid     : request present on aluop/func/shamt
//   in_ready     : request accepted when in_valid && in_ready at a rising edge
//   aluop, func  : opcode class and R-type function field
//   shamt        : shift amount for SLL requests
//   mul_bit      : current multiplier LSB, used during MUL steps
//   aluctr       : ALU micro-op for this cycle
//   uop_valid    : aluctr is live this cycle
//   shift_en     : datapath shifts multiplier/product registers this cycle
//   busy         : a multi-cycle operation is in progress
//   done         : last micro-op of the accepted request is issued this cycle
module multicycle_alucontrol
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         aluop,
  input  logic [2:0]         func,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               mul_bit,
  output logic [2:0]         aluctr,
  output logic               uop_valid,
  output logic               shift_en,
  output logic               busy,
  output logic               done
);

  state_e             state, state_d;
  logic [SHAMT_W-1:0] cnt, cnt_d;
  // Pending single-cycle issue, presented the cycle after acceptance.
  logic               issue, issue_d;
  aluctr_e            issue_ctr, issue_ctr_d;

  aluctr_e dec_ctr, ctr_out;
  logic    dec_mul, dec_sll;
  logic    accept;

  alucontrol_dec u_dec (
    .aluop  (aluop),
    .func   (func),
    .ctr    (dec_ctr),
    .is_mul (dec_mul),
    .is_sll (dec_sll)
  );

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign aluctr   = ctr_out;

  // NOTE: state updates use non-blocking assignments so every register samples
  // values from before the edge regardless of statement order.
  // NOTE: reset is asynchronous; all outputs are derived from these registers,
  // so they take their idle values as soon as reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      issue     <= 1'b0;
      issue_ctr <= CTR_PASS;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      issue     <= issue_d;
      issue_ctr <= issue_ctr_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    issue_d     = 1'b0;
    issue_ctr_d = CTR_PASS;
    ctr_out     = CTR_PASS;
    uop_valid   = 1'b0;
    shift_en    = 1'b0;
    done        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (issue) begin
          ctr_out   = issue_ctr;
          uop_valid = 1'b1;
          done      = 1'b1;
        end
        if (accept) begin
          if (dec_mul) begin
            state_d = ST_MUL;
            cnt_d   = SHAMT_W'(DATA_W - 1);
          end else if (dec_sll && (shamt != '0)) begin
            state_d = ST_SHF;
            cnt_d   = shamt - 1'b1;
          end else begin
            // SLL by zero falls through here; the decoder gives PASS for it.
            issue_d     = 1'b1;
            issue_ctr_d = dec_ctr;
          end
        end
      end

      ST_MUL: begin
        uop_valid = 1'b1;
        shift_en  = 1'b1;
        ctr_out   = mul_bit ? CTR_ADD : CTR_PASS;
        done      = (cnt == '0);
        if (done) state_d = ST_IDLE;
        else      cnt_d   = cnt - 1'b1;
      end

      ST_SHF: begin
        uop_valid = 1'b1;
        ctr_out   = CTR_SLL1;
        done      = (cnt == '0);
        if (done) state_d = ST_IDLE;
        else      cnt_d   = cnt - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
